// File: rtl/mqc_r.sv
// mqc_r -- receive-side parser for the MQC telemetry word stream.
//
// The stream is a sequence of header words {12'h000, chan[4:0], MAGIC[14:0]},
// each followed by data words. Slot channels 0..NCHAN-1 carry SLOT_LEN words
// (header included). One word per slot, at CAP_OFS after the header, is
// captured into a shadow bank and announced on ovalid/ochan/odata. Channel
// NCHAN (Tcorr) carries a TCORR_LEN-word burst that is forwarded as an indexed
// sample stream. The header cadence is checked, and the parser drops back to
// hunting whenever the cadence breaks.
//
// Ports:
//   iclk, ireset      clock, synchronous active-high reset
//   ipack, ipack_vld  stream word and its valid strobe (idle cycles freeze the parser)
//   irdaddr, ordata   shadow bank read port, one cycle latency, 0 above NCHAN
//   ovalid/ochan/odata            captured-word pulse, channel, data
//   otcorr_vld/idx/data/done      Tcorr sample stream and end-of-burst pulse
//   olock                         parser is locked to the header cadence
//   oseq_err, oerr_cnt            cadence-error pulse and saturating error count
module mqc_r #(
   parameter logic [14:0] MAGIC     = 15'h0AFA,
   parameter int          NCHAN     = 17,
   parameter int          SLOT_LEN  = 3,
   parameter int          CAP_OFS   = 2,
   parameter int          TCORR_LEN = 200000
) (
   input  logic        iclk,
   input  logic        ireset,
   input  logic [31:0] ipack,
   input  logic        ipack_vld,
   input  logic [4:0]  irdaddr,
   output logic [31:0] ordata,
   output logic        ovalid,
   output logic [4:0]  ochan,
   output logic [31:0] odata,
   output logic        otcorr_vld,
   output logic [17:0] otcorr_idx,
   output logic [31:0] otcorr_data,
   output logic        otcorr_done,
   output logic        olock,
   output logic        oseq_err,
   output logic [15:0] oerr_cnt
);

   localparam int             WCW    = $clog2(SLOT_LEN);
   localparam logic [4:0]     CH_T   = 5'(NCHAN);
   localparam logic [4:0]     CH_END = 5'(NCHAN - 1);
   localparam logic [WCW-1:0] W_CAP  = WCW'(CAP_OFS - 1);
   localparam logic [WCW-1:0] W_END  = WCW'(SLOT_LEN - 1);
   localparam logic [17:0]    T_LEN  = 18'(TCORR_LEN);

   typedef enum logic [1:0] {HUNT, SLOT, TCORR} state_t;

   state_t         state, state_nx;
   logic [WCW-1:0] wcnt, wcnt_nx;
   logic [4:0]     cur, cur_nx;
   logic [4:0]     expc, expc_nx;
   logic [17:0]    idx, idx_nx;
   logic [31:0]    bank [0:NCHAN];

   logic           hdr;
   logic [4:0]     hdr_ch;
   logic           enter;
   logic [4:0]     enter_ch;
   logic           cap, smp, done, err;
   logic           bank_we;
   logic [4:0]     bank_wa;

   function automatic logic is_hdr(input logic [31:0] w);
      return (w[31:20] == 12'h000) && (w[14:0] == MAGIC) && (w[19:15] <= CH_T);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign hdr    = is_hdr(ipack);
   assign hdr_ch = ipack[19:15];
   assign olock  = (state != HUNT);

   always_ff @(posedge iclk) begin
      if (ireset) state <= HUNT;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      wcnt_nx  = wcnt;
      cur_nx   = cur;
      expc_nx  = expc;
      idx_nx   = idx;
      enter    = 1'b0;
      enter_ch = hdr_ch;
      cap      = 1'b0;
      smp      = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      bank_we  = 1'b0;
      bank_wa  = cur;
      if (ipack_vld) begin
         case (state)
            HUNT: enter = hdr;
            SLOT: begin
               if (wcnt == W_END) begin
                  // Next-header position: the expected channel, or a wrap to 0 after the last slot.
                  if (hdr && ((hdr_ch == expc) || ((cur == CH_END) && (hdr_ch == 5'd0))))
                     enter = 1'b1;
                  else begin
                     err      = 1'b1;
                     state_nx = HUNT;
                  end
               end else begin
                  if (wcnt == W_CAP) begin
                     cap     = 1'b1;
                     bank_we = 1'b1;
                  end
                  wcnt_nx = wcnt + 1'b1;
               end
            end
            TCORR: begin
               if (idx == T_LEN) begin
                  if (hdr && (hdr_ch == 5'd0)) begin
                     done     = 1'b1;
                     enter    = 1'b1;
                     enter_ch = 5'd0;
                  end else begin
                     err      = 1'b1;
                     state_nx = HUNT;
                  end
               end else begin
                  // Burst words are samples whatever they look like.
                  smp     = 1'b1;
                  bank_we = 1'b1;
                  bank_wa = CH_T;
                  idx_nx  = idx + 1'b1;
               end
            end
            default: state_nx = HUNT;
         endcase
      end
      if (enter) begin
         if (enter_ch == CH_T) begin
            state_nx = TCORR;
            idx_nx   = 18'd0;
         end else begin
            state_nx = SLOT;
            wcnt_nx  = '0;
            cur_nx   = enter_ch;
            expc_nx  = enter_ch + 5'd1;
         end
      end
   end

   always_ff @(posedge iclk) begin
      if (ireset) begin
         wcnt        <= '0;
         cur         <= '0;
         expc        <= '0;
         idx         <= '0;
         ordata      <= '0;
         ovalid      <= 1'b0;
         ochan       <= '0;
         odata       <= '0;
         otcorr_vld  <= 1'b0;
         otcorr_idx  <= '0;
         otcorr_data <= '0;
         otcorr_done <= 1'b0;
         oseq_err    <= 1'b0;
         oerr_cnt    <= '0;
         for (int i = 0; i <= NCHAN; i++) bank[i] <= '0;
      end else begin
         wcnt        <= wcnt_nx;
         cur         <= cur_nx;
         expc        <= expc_nx;
         idx         <= idx_nx;
         // Read samples the bank before this cycle's write lands: same-address reads see the old word.
         ordata      <= (irdaddr <= CH_T) ? bank[irdaddr] : 32'd0;
         ovalid      <= cap;
         otcorr_vld  <= smp;
         otcorr_done <= done;
         oseq_err    <= err;
         if (cap) begin
            ochan <= cur;
            odata <= ipack;
         end
         if (smp) begin
            otcorr_idx  <= idx;
            otcorr_data <= ipack;
         end
         if (err)     oerr_cnt      <= sat_inc(oerr_cnt);
         if (bank_we) bank[bank_wa] <= ipack;
      end
   end

endmodule
